// File: rtl/mul16_seq_ctrl.sv
// Iterative shift-and-add multiplier sequencer.
// It produces the low 16 bits of an unsigned 16x16 product.
// One 16-bit ripple adder is reused over up to 16 iterations.
// Control uses a start/busy/done handshake.

// 16-bit ripple-carry adder. There is no carry-out; the sum wraps modulo 2^16.
module fulladder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [15:0] carry_s;

    // Ripple the carry from bit 0 upward; the carry out of bit 15 is never formed.
    always_comb begin
        carry_s[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign sum = a ^ b ^ carry_s;

endmodule

module mul16_seq_ctrl #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] mcand_r;
    logic [15:0] mcand_nxt_s;
    logic [15:0] mplier_r;
    logic [15:0] mplier_nxt_s;
    logic [15:0] acc_r;
    logic [15:0] acc_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        busy_r;
    logic        done_r;
    logic [15:0] sum_s;
    logic [15:0] mplier_shift_s;
    logic        last_iter_s;

    // The only adder in the block: acc + mcand.
    fulladder16 u_add (
        .a   (acc_r),
        .b   (mcand_r),
        .sum (sum_s)
    );

    assign mplier_shift_s = {1'b0, mplier_r[15:1]};

    // Stop after the 16th iteration. With early exit, also stop once no multiplier bits remain.
    always_comb begin
        if (cnt_r == 4'd15) begin
            last_iter_s = 1'b1;
        end else if ((EARLY_EXIT == 1'b1) && (mplier_shift_s == 16'd0)) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
    end

    // Next-state and datapath update; every register holds unless the state says otherwise.
    always_comb begin
        state_nxt_s  = state_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    mcand_nxt_s  = a;
                    mplier_nxt_s = b;
                    acc_nxt_s    = 16'd0;
                    cnt_nxt_s    = 4'd0;
                    state_nxt_s  = RUN;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            RUN: begin
                if (mplier_r[0]) begin
                    acc_nxt_s = sum_s;
                end else begin
                    acc_nxt_s = acc_r;
                end
                mcand_nxt_s  = {mcand_r[14:0], 1'b0};
                mplier_nxt_s = mplier_shift_s;
                cnt_nxt_s    = cnt_r + 4'd1;
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset. busy and done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            mcand_r  <= 16'd0;
            mplier_r <= 16'd0;
            acc_r    <= 16'd0;
            cnt_r    <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            acc_r    <= acc_nxt_s;
            cnt_r    <= cnt_nxt_s;
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= (state_nxt_s == DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench for mul16_seq_ctrl.
// Both EARLY_EXIT settings run side by side on shared inputs.
// Results are compared with a behavioural model of product and latency.
module tb_mul16_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy0, done0;
    logic [15:0] product0;
    logic        busy1, done1;
    logic [15:0] product1;

    int n_checks = 0;
    int n_pass   = 0;

    mul16_seq_ctrl #(.EARLY_EXIT(1'b0)) dut_fixed (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy0),
        .done    (done0),
        .product (product0)
    );

    mul16_seq_ctrl #(.EARLY_EXIT(1'b1)) dut_early (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy1),
        .done    (done1),
        .product (product1)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Iteration count: 16 when fixed; otherwise max(1, MSB position of b + 1).
    function automatic int exp_iters(input bit ee, input logic [15:0] bv);
        int n;
        if (!ee) return 16;
        n = 1;
        for (int i = 0; i < 16; i++) begin
            if (bv[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_prod(input logic [15:0] av, input logic [15:0] bv);
        logic [31:0] full;
        full = 32'(av) * 32'(bv);
        return full[15:0];
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy0"}, 32'(busy0), 32'd0);
        chk({tag, "_done0"}, 32'(done0), 32'd0);
        chk({tag, "_prod0"}, 32'(product0), 32'd0);
        chk({tag, "_busy1"}, 32'(busy1), 32'd0);
        chk({tag, "_done1"}, 32'(done1), 32'd0);
        chk({tag, "_prod1"}, 32'(product1), 32'd0);
    endtask

    // One multiply: start is accepted at E0, then busy, done and product are checked every cycle.
    // With hold > 0, start stays high with a=b=9 through cycle 'hold'; both units must ignore it.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int hold);
        int n0, n1, last;
        logic [15:0] expp;
        n0   = exp_iters(1'b0, bv);
        n1   = exp_iters(1'b1, bv);
        expp = exp_prod(av, bv);
        last = n0 + 11;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            chk("busy_fixed", 32'(busy0), 32'(cyc <= n0 + 1));
            chk("done_fixed", 32'(done0), 32'(cyc == n0 + 1));
            if (cyc >= n0 + 1) chk("prod_fixed", 32'(product0), 32'(expp));
            chk("busy_early", 32'(busy1), 32'(cyc <= n1 + 1));
            chk("done_early", 32'(done1), 32'(cyc == n1 + 1));
            if (cyc >= n1 + 1) chk("prod_early", 32'(product1), 32'(expp));
            if (cyc <= hold) begin
                start = 1'b1; a = 16'd9; b = 16'd9;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;

        // Reset for two cycles, then a few idle cycles
        @(posedge clk); @(negedge clk); check_idle_zero("rst1");
        @(posedge clk); @(negedge clk); check_idle_zero("rst2");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk); check_idle_zero("idle");
        end

        // Directed cases
        run_op(16'h0003, 16'h0005, 0);
        run_op(16'h1234, 16'h0000, 0);
        run_op(16'h0007, 16'h8000, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(16'h0100, 16'h0100, 0);
        run_op(16'h00FF, 16'h0101, 0);

        // start while busy (RUN, and DONE for the early-exit unit) is ignored
        run_op(16'h0002, 16'h0003, 3);
        run_op(16'h0009, 16'h0009, 0);

        // Reset in RUN cycle 3 discards the operation
        @(negedge clk);
        a = 16'h00FF; b = 16'h00FF; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); check_idle_zero("midrst");
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk); check_idle_zero("postrst");
        end
        run_op(16'h0004, 16'h0004, 0);

        // Randomized operands, with b's width varied to exercise early-exit latency
        for (int k = 0; k < 25; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run_op(ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
